// File: rtl/lag_measure_pkg.sv
// Shared types and sizing helpers for the multi-channel lag measurement block.
package lag_measure_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } chan_state_e;

  localparam int unsigned DEF_COUNT_WIDTH = 16;
  localparam int unsigned DEF_AVG_LOG2    = 4;
  localparam int unsigned DEF_SUM_WIDTH   = DEF_COUNT_WIDTH + DEF_AVG_LOG2;

  // Running-sum width: one sample width plus headroom for the whole window.
  function automatic int unsigned sum_width(input int unsigned count_width,
                                            input int unsigned avg_log2);
    return count_width + avg_log2;
  endfunction

endpackage

// File: rtl/lag_channel.sv
// One lag-measurement channel: arm/capture FSM, tick counter, min/max and moving average.
// Optional timeout abort is built when LAG_MEASURE_TIMEOUT_EN is defined.
module lag_channel
  import lag_measure_pkg::*;
#(
  parameter int unsigned             COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int unsigned             AVG_LOG2    = DEF_AVG_LOG2,
  parameter logic [COUNT_WIDTH-1:0]  TIMEOUT     = 16'd20000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   start,
  input  logic                   clear_stats,
  input  logic                   trigger,
  output logic [COUNT_WIDTH-1:0] current,
  output logic [COUNT_WIDTH-1:0] minimum,
  output logic [COUNT_WIDTH-1:0] maximum,
  output logic [COUNT_WIDTH-1:0] average,
  output logic                   avg_valid,
  output logic                   sample_valid,
  output logic                   timed_out
);

  localparam int unsigned        SUM_WIDTH = sum_width(COUNT_WIDTH, AVG_LOG2);
  localparam int unsigned        DEPTH     = 1 << AVG_LOG2;
  localparam logic [AVG_LOG2:0]  FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);

  chan_state_e                state_q, state_d;
  logic [COUNT_WIDTH-1:0]     count_q, count_d;
  logic [COUNT_WIDTH-1:0]     current_q, current_d;
  logic [COUNT_WIDTH-1:0]     min_q, min_d;
  logic [COUNT_WIDTH-1:0]     max_q, max_d;
  logic [COUNT_WIDTH-1:0]     buf_q [DEPTH];
  logic [COUNT_WIDTH-1:0]     buf_d [DEPTH];
  logic [AVG_LOG2-1:0]        ptr_q, ptr_d;
  logic [SUM_WIDTH-1:0]       sum_q, sum_d;
  logic [AVG_LOG2:0]          fill_q, fill_d;
  logic [COUNT_WIDTH-1:0]     avg_q, avg_d;
  logic                       avg_valid_q, avg_valid_d;
  logic                       sample_q, sample_d;
`ifdef LAG_MEASURE_TIMEOUT_EN
  logic                       timed_out_q, timed_out_d;
`endif

  logic                       capture;
  logic [COUNT_WIDTH-1:0]     base_min, base_max, evicted;
  logic [SUM_WIDTH-1:0]       base_sum;
  logic [AVG_LOG2:0]          base_fill;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    current_d   = current_q;
    min_d       = min_q;
    max_d       = max_q;
    buf_d       = buf_q;
    ptr_d       = ptr_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    avg_d       = avg_q;
    avg_valid_d = avg_valid_q;
    sample_d    = 1'b0;
`ifdef LAG_MEASURE_TIMEOUT_EN
    timed_out_d = 1'b0;
`endif
    capture     = (state_q == ARMED) && trigger;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          count_d = '0;
        end
      end
      ARMED: begin
        if (start) begin
          count_d = '0;
        end else if (trigger) begin
          state_d = IDLE;
        end
`ifdef LAG_MEASURE_TIMEOUT_EN
        else if (count_q >= TIMEOUT) begin
          state_d     = IDLE;
          timed_out_d = 1'b1;
        end
`endif
        else if (tick && (count_q != '1)) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear coincident with a capture is applied first, so the capture seeds fresh stats.
    base_min  = clear_stats ? '1 : min_q;
    base_max  = clear_stats ? '0 : max_q;
    base_sum  = clear_stats ? '0 : sum_q;
    base_fill = clear_stats ? '0 : fill_q;
    evicted   = (base_fill == FILL_FULL) ? buf_q[ptr_q] : '0;

    if (clear_stats) begin
      min_d  = '1;
      max_d  = '0;
      sum_d  = '0;
      fill_d = '0;
    end

    if (capture) begin
      current_d    = count_q;
      sample_d     = 1'b1;
      min_d        = (count_q < base_min) ? count_q : base_min;
      max_d        = (count_q > base_max) ? count_q : base_max;
      buf_d[ptr_q] = count_q;
      ptr_d        = ptr_q + 1'b1;
      sum_d        = base_sum + SUM_WIDTH'(count_q) - SUM_WIDTH'(evicted);
      fill_d       = (base_fill == FILL_FULL) ? FILL_FULL : base_fill + 1'b1;
    end

    // Average is registered from the sum stage, one cycle behind the capture.
    if (clear_stats) begin
      avg_d       = '0;
      avg_valid_d = 1'b0;
    end else begin
      avg_valid_d = (fill_q == FILL_FULL);
      avg_d       = (fill_q == FILL_FULL) ? sum_q[SUM_WIDTH-1:AVG_LOG2] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      current_q   <= '0;
      min_q       <= '1;
      max_q       <= '0;
      buf_q       <= '{default: '0};
      ptr_q       <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      sample_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      current_q   <= current_d;
      min_q       <= min_d;
      max_q       <= max_d;
      buf_q       <= buf_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      sample_q    <= sample_d;
    end
  end

`ifdef LAG_MEASURE_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) timed_out_q <= 1'b0;
    else       timed_out_q <= timed_out_d;
  end
  assign timed_out = timed_out_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timed_out      = 1'b0;
`endif

  assign current      = current_q;
  assign minimum      = min_q;
  assign maximum      = max_q;
  assign average      = avg_q;
  assign avg_valid    = avg_valid_q;
  assign sample_valid = sample_q;

endmodule

// File: rtl/lag_measure_array.sv
// Multi-channel lag measurement: shared tick prescaler plus CHANNELS lag_channel instances.
// Per-channel timeout is built when LAG_MEASURE_TIMEOUT_EN is defined.
module lag_measure_array
  import lag_measure_pkg::*;
#(
  parameter int unsigned            CHANNELS    = 2,
  parameter int unsigned            COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int unsigned            PRESCALE    = 2700,
  parameter int unsigned            AVG_LOG2    = DEF_AVG_LOG2,
  parameter logic [COUNT_WIDTH-1:0] TIMEOUT     = 16'd20000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            clear_stats,
  input  logic [CHANNELS-1:0]             sensor_trigger,
  output logic [CHANNELS*COUNT_WIDTH-1:0] current,
  output logic [CHANNELS*COUNT_WIDTH-1:0] minimum,
  output logic [CHANNELS*COUNT_WIDTH-1:0] maximum,
  output logic [CHANNELS*COUNT_WIDTH-1:0] average,
  output logic [CHANNELS-1:0]             avg_valid,
  output logic [CHANNELS-1:0]             sample_valid,
  output logic [CHANNELS-1:0]             timed_out
);

  localparam int unsigned      PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = presc_q + 1'b1;
    if (start || tick) presc_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    lag_channel #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .AVG_LOG2    (AVG_LOG2),
      .TIMEOUT     (TIMEOUT)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .tick         (tick),
      .start        (start),
      .clear_stats  (clear_stats),
      .trigger      (sensor_trigger[i]),
      .current      (current[i*COUNT_WIDTH +: COUNT_WIDTH]),
      .minimum      (minimum[i*COUNT_WIDTH +: COUNT_WIDTH]),
      .maximum      (maximum[i*COUNT_WIDTH +: COUNT_WIDTH]),
      .average      (average[i*COUNT_WIDTH +: COUNT_WIDTH]),
      .avg_valid    (avg_valid[i]),
      .sample_valid (sample_valid[i]),
      .timed_out    (timed_out[i])
    );
  end

endmodule
